// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive front-end: FSM encodings and
// baud-timing derivations used by the receiver and its bench.
package uart_rx_fifo_pkg;

    localparam int BYTE_W     = 8;
    localparam int DEF_CLK_HZ = 12000000;
    localparam int DEF_BAUD   = 115200;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_WAITHI = 3'd4
    } rx_state_t;

    function automatic int bit_cyc_of(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    function automatic int half_of(input int clk_hz, input int baud);
        return bit_cyc_of(clk_hz, baud) / 2;
    endfunction

    function automatic int cnt_w_of(input int clk_hz, input int baud);
        int b;
        b = bit_cyc_of(clk_hz, baud);
        return (b > 1) ? $clog2(b) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Read-side valid/ready handshake carrying received bytes to the consumer.
interface uart_rx_fifo_if;

    logic [7:0] DATA;
    logic       VALID;
    logic       READY;

    modport master (output DATA, output VALID, input READY);
    modport slave  (input DATA, input VALID, output READY);

endinterface

// File: rtl/uart_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so full and
// empty are told apart by the MSB alone.
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, 2-FF line synchroniser and a
// small output FIFO read through a valid/ready handshake.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLK_HZ = DEF_CLK_HZ,
    parameter int BAUD   = DEF_BAUD,
    parameter int DEPTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RESn,
    input  logic                  RXD,
    uart_rx_fifo_if.master        rd_bus,
    output logic                  FERR,
    output logic                  OVR,
    input  logic                  CLR,
    output logic                  BUSY
);

    localparam int BIT_CYC = bit_cyc_of(CLK_HZ, BAUD);
    localparam int HALF    = half_of(CLK_HZ, BAUD);
    localparam int CNT_W   = cnt_w_of(CLK_HZ, BAUD);

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);

    logic              sync_p0;
    logic              sync_p1;
    logic              rs;

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_nxt;
    logic              shift_en;
    logic              push;
    logic              ferr_set;

    logic [BYTE_W-1:0] shreg;
    logic [BYTE_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              ovr_set;
    logic              ferr_q;
    logic              ovr_q;

    // Synchroniser resets high so a line held low through reset is not a start.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= RXD;
            sync_p1 <= sync_p0;
        end
    end

    assign rs = sync_p1;

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shift_en    = 1'b0;
        push        = 1'b0;
        ferr_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!rs) state_nxt = ST_START;
            end
            ST_START: begin
                if (cnt == CNT_HALF_END) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_nxt     = '0;
                    shift_en    = 1'b1;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_nxt = '0;
                    if (rs) begin
                        push      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_set  = 1'b1;
                        state_nxt = ST_WAITHI;
                    end
                end
            end
            ST_WAITHI: begin
                // Hold off until the line returns high so a break flags only once.
                cnt_nxt = '0;
                if (rs) state_nxt = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (shift_en) shreg <= {rs, shreg[BYTE_W-1:1]};
    end

    assign pop     = !fifo_empty && rd_bus.READY;
    assign ovr_set = push && fifo_full && !pop;

    uart_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RESn),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // New overrun takes priority over a clear in the same cycle.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            ferr_q <= ferr_set;
            if (ovr_set)  ovr_q <= 1'b1;
            else if (CLR) ovr_q <= 1'b0;
        end
    end

    assign rd_bus.DATA  = fifo_empty ? '0 : fifo_head;
    assign rd_bus.VALID = !fifo_empty;
    assign FERR         = ferr_q;
    assign OVR          = ovr_q;
    assign BUSY         = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 12 MHz / 115200 baud (104 clocks per bit).
module tb_uart_rx_fifo;

    localparam int BIT = 104;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;
    logic clr   = 1'b0;
    logic ferr;
    logic ovr;
    logic busy;

    uart_rx_fifo_if rif ();

    uart_rx_fifo #(
        .CLK_HZ (12000000),
        .BAUD   (115200),
        .DEPTH  (4)
    ) dut (
        .CLK    (clk),
        .RESn   (rst_n),
        .RXD    (rxd),
        .rd_bus (rif),
        .FERR   (ferr),
        .OVR    (ovr),
        .CLR    (clr),
        .BUSY   (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] rx_q [$];
    int         ferr_cnt = 0;
    int         rise_cyc = -1;
    logic       prev_v   = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rif.VALID && rif.READY) rx_q.push_back(rif.DATA);
        if (ferr) ferr_cnt = ferr_cnt + 1;
        if (rif.VALID && !prev_v) rise_cyc = cyc;
        prev_v = rif.VALID;
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int i);
        if (i < rx_q.size()) return int'(rx_q[i]);
        return -1;
    endfunction

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t_edge);
        @(posedge clk);
        #1 rxd = 1'b0;
        t_edge = cyc;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rxd = b[i];
            repeat (BIT) @(posedge clk);
        end
        #1 rxd = stop_bit;
        repeat (BIT - 1) @(posedge clk);
    endtask

    int te;
    int lat;

    initial begin
        rif.READY = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", rif.VALID, 0);
        chk("rst_data",  rif.DATA,  0);
        chk("rst_ferr",  ferr,      0);
        chk("rst_ovr",   ovr,       0);
        chk("rst_busy",  busy,      0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // single 0x55 frame, consumer always ready
        rif.READY = 1'b1;
        rx_q.delete();
        ferr_cnt = 0;
        rise_cyc = -1;
        send_frame(8'h55, 1'b1, te);
        repeat (20) @(posedge clk);
        #1;
        lat = rise_cyc - te;
        chk("t1_latency_991pm1", int'(lat >= 990 && lat <= 992), 1);
        chk("t1_count", rx_q.size(), 1);
        chk("t1_data",  q_at(0), 'h55);
        chk("t1_valid_after", rif.VALID, 0);
        chk("t1_ferr", ferr_cnt, 0);
        chk("t1_ovr",  ovr, 0);

        // 20-cycle glitch is rejected at the start mid-bit
        rx_q.delete();
        @(posedge clk);
        #1 rxd = 1'b0;
        te = cyc;
        goto(te + 2);
        chk("t2_busy_t0", busy, 0);
        goto(te + 3);
        chk("t2_busy_t0p1", busy, 1);
        goto(te + 20);
        rxd = 1'b1;
        goto(te + 50);
        chk("t2_busy_mid", busy, 1);
        goto(te + 60);
        chk("t2_busy_idle", busy, 0);
        chk("t2_valid", rif.VALID, 0);
        chk("t2_count", rx_q.size(), 0);

        // bad stop bit followed by a break, then a clean frame
        rx_q.delete();
        ferr_cnt = 0;
        send_frame(8'hA3, 1'b0, te);
        goto(te + 1039 + 3 * BIT);
        chk("t3_busy_break", busy, 1);
        chk("t3_ferr_once", ferr_cnt, 1);
        chk("t3_no_valid", rx_q.size(), 0);
        rxd = 1'b1;
        goto(te + 1039 + 3 * BIT + 5);
        chk("t3_busy_released", busy, 0);
        repeat (20) @(posedge clk);
        send_frame(8'h3C, 1'b1, te);
        repeat (20) @(posedge clk);
        #1;
        chk("t3_count", rx_q.size(), 1);
        chk("t3_data",  q_at(0), 'h3C);
        chk("t3_ferr_total", ferr_cnt, 1);

        // fill past depth with the consumer stalled
        rif.READY = 1'b0;
        rx_q.delete();
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1'b1, te);
            #1;
            if (b == 4) chk("t4_ovr_at_full", ovr, 0);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("t4_valid", rif.VALID, 1);
        chk("t4_head",  rif.DATA, 'h01);
        chk("t4_ovr",   ovr, 1);
        rif.READY = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rif.READY = 1'b0;
        chk("t4_drain_count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_drain_%0d", i), q_at(i), i + 1);
        chk("t4_empty", rif.VALID, 0);
        chk("t4_ovr_sticky", ovr, 1);
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        chk("t4_ovr_cleared", ovr, 0);

        // back-to-back frames
        rif.READY = 1'b1;
        rx_q.delete();
        ferr_cnt = 0;
        send_frame(8'h00, 1'b1, te);
        send_frame(8'hFF, 1'b1, te);
        send_frame(8'h80, 1'b1, te);
        repeat (30) @(posedge clk);
        #1;
        chk("t5_count", rx_q.size(), 3);
        chk("t5_b0", q_at(0), 'h00);
        chk("t5_b1", q_at(1), 'hFF);
        chk("t5_b2", q_at(2), 'h80);
        chk("t5_ferr", ferr_cnt, 0);

        // reset mid-frame discards the frame and the buffered byte
        rif.READY = 1'b0;
        rx_q.delete();
        send_frame(8'h11, 1'b1, te);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_pre_valid", rif.VALID, 1);
        chk("t6_pre_data",  rif.DATA, 'h11);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 rxd = i[0];
            repeat (BIT) @(posedge clk);
        end
        #1 rxd = 1'b1;
        repeat (50) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", rif.VALID, 0);
        chk("t6_rst_data",  rif.DATA, 0);
        chk("t6_rst_busy",  busy, 0);
        chk("t6_rst_ferr",  ferr, 0);
        chk("t6_rst_ovr",   ovr, 0);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        rif.READY = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t6_nothing_delivered", rx_q.size(), 0);
        send_frame(8'h7E, 1'b1, te);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_count", rx_q.size(), 1);
        chk("t6_data",  q_at(0), 'h7E);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
